sync_frame_tx: RTL
==================

Name: sync_frame_tx

Overview:
Serial frame transmitter, the send side of the 1011 sync-word link.
- Accepts DATA_W-bit words over a valid/ready handshake.
- Prepends a SYNC_LEN-bit sync pattern (default 1011) to each frame of FRAME_WORDS words.
- Shifts everything out MSB-first, one bit per clock, with a qualifying dout_valid.
- Downstream receivers find frame starts with a sequence detector on dout.

Parameters:
SYNC_PATTERN, 4'b1011, sync word, sent MSB-first; width SYNC_LEN
SYNC_LEN, 4, sync word length in bits (>=1)
DATA_W, 8, payload word width (>=1)
FRAME_WORDS, 2, payload words per frame (>=1)
IDLE_BIT, 1'b0, line level driven on dout whenever dout_valid=0

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a word
in_data  input  DATA_W  payload word
in_ready  output  1  block accepts a word this cycle; transfer = in_valid & in_ready at the rising edge
dout  output  1  serial line bit (registered)
dout_valid  output  1  dout carries a sync or payload bit (registered)
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse after the last payload bit
frame_count  output  8  frames completed, wraps 255->0

Behaviour:
- Reset: async assert forces state=IDLE, dout=IDLE_BIT, dout_valid=0, frame_done=0, frame_count=0, shift reg/counters=0. Deassertion is sampled at the next clk edge. A partial frame is discarded. No bit of it is re-sent.
- FSM states: IDLE, SYNC, DATA, STALL, GAP. in_ready is combinational from state/counters.
- IDLE:
  - in_ready=1, dout_valid=0, dout=IDLE_BIT.
  - On transfer: capture in_data into shift reg, word_idx=0, go SYNC.
- SYNC:
  - dout=SYNC_PATTERN[SYNC_LEN-1-bit_cnt], dout_valid=1, in_ready=0.
  - Lasts exactly SYNC_LEN cycles, then DATA with bit_cnt=0.
  - The first sync bit is visible in the cycle after the accepting edge.
- DATA:
  - dout=shift reg MSB, dout_valid=1. Shift left each cycle for DATA_W cycles.
  - in_ready=1 only in the cycle showing the last bit of a word and when word_idx<FRAME_WORDS-1.
  - Transfer in that cycle: load the new word and increment word_idx. The next cycle shows its MSB, with no bubble.
  - No transfer while more words are owed: go STALL.
  - Last bit of the last word: go GAP.
- STALL:
  - dout_valid=0, dout=IDLE_BIT, in_ready=1.
  - On transfer: load the word, increment word_idx, go DATA.
  - The sync pattern is NOT resent.
  - No timeout; a stall can last indefinitely.
- GAP:
  - One cycle. dout_valid=0, dout=IDLE_BIT, in_ready=0, frame_done=1.
  - frame_count increments at the entry edge (mod 256). Then go IDLE.
- Back-to-back frames: at least 2 dout_valid=0 cycles between frames (GAP + IDLE accept cycle).
- in_data is ignored when in_ready=0. in_valid may drop without a transfer; no protocol error is flagged.
- Counter widths: bit_cnt is clog2(max(SYNC_LEN,DATA_W)) bits; word_idx is clog2(FRAME_WORDS)+1 bits.
- frame_done and busy are registered together with the state.

Test Plan:
1. Assert rstn=0 for 3 cycles, then release -> dout=0, dout_valid=0, busy=0, in_ready=1, frame_count=0. Outputs are already 0 before the first clk edge.
2. Defaults; in_valid held with 8'hA5, then 8'h3C -> dout = 1011 10100101 00111100 over 20 consecutive dout_valid cycles. in_ready pulses at the accept edge and on bit 7 of word 0. frame_done pulses once, 1 cycle after the last bit. frame_count=1.
3. Same frame, but in_valid low for 3 cycles at the word boundary -> exactly 3 STALL cycles (dout_valid=0, dout=0, in_ready=1). No resend of 1011. The concatenated valid bits equal scenario 2.
4. 3 frames with in_valid held high -> each frame is 20 valid bits separated by exactly 2 invalid cycles. frame_count steps 1,2,3. Then preload frame_count at 255 and send one frame -> frame_count reads 0.
5. Pull rstn low mid-DATA (bit 3 of word 1), asynchronously between edges -> dout_valid=0, busy=0 immediately. After release, a new frame of 8'hFF, 8'h00 streams a clean 1011 header.
6. Loop dout into a bench 1011 Mealy sequence-detector model, payload 8'h00, 8'h00, 5 frames -> exactly 5 detections, each on the 4th sync bit.

Source files
------------

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter for the sync-word link.
// Each frame carries SYNC_PATTERN followed by FRAME_WORDS payload words,
// all shifted out MSB-first with dout_valid qualifying every line bit.
// All line-side outputs are registered; in_ready is decoded from the state.
module sync_frame_tx #(
    parameter int unsigned          SYNC_LEN     = 4,
    parameter logic [SYNC_LEN-1:0]  SYNC_PATTERN = 4'b1011,
    parameter int unsigned          DATA_W       = 8,
    parameter int unsigned          FRAME_WORDS  = 2,
    parameter logic                 IDLE_BIT     = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count
);

    localparam int unsigned MAX_W  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int unsigned CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int unsigned WIDX_W = $clog2(FRAME_WORDS) + 1;

    localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_STALL = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    state_e              state_q,       state_d;
    logic [CNT_W-1:0]    bit_cnt_q,     bit_cnt_d;
    logic [WIDX_W-1:0]   word_idx_q,    word_idx_d;
    logic [DATA_W-1:0]   shift_q,       shift_d;
    logic                dout_q,        dout_d;
    logic                dout_valid_q,  dout_valid_d;
    logic                busy_q,        busy_d;
    logic                frame_done_q,  frame_done_d;
    logic [7:0]          frame_count_q, frame_count_d;

    logic                in_ready_s;
    logic                more_words_s;
    logic [SYNC_LEN-1:0] sync_word_s;

    assign more_words_s = (word_idx_q < WORD_LAST);

    // Next-state, counter and shift-register control; also decodes in_ready.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_idx_d = word_idx_q;
        shift_d    = shift_q;
        in_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_d    = ST_SYNC;
                    shift_d    = in_data;
                    word_idx_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (bit_cnt_q == SYNC_LAST) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == DATA_LAST) begin
                    bit_cnt_d = '0;
                    if (more_words_s) begin
                        // Offer the next word exactly while its predecessor's last bit is on the line.
                        in_ready_s = 1'b1;
                        if (in_valid) begin
                            shift_d    = in_data;
                            word_idx_d = word_idx_q + WIDX_W'(1);
                        end else begin
                            state_d    = ST_STALL;
                        end
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_STALL: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_d    = ST_DATA;
                    shift_d    = in_data;
                    word_idx_d = word_idx_q + WIDX_W'(1);
                    bit_cnt_d  = '0;
                end else begin
                    state_d    = ST_STALL;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                bit_cnt_d  = '0;
                word_idx_d = '0;
                shift_d    = '0;
            end
        endcase
    end

    // Output pre-computation from the next state so the registered line bit lines up with it.
    always_comb begin
        sync_word_s  = SYNC_PATTERN << bit_cnt_d;
        dout_d       = IDLE_BIT;
        dout_valid_d = 1'b0;
        case (state_d)
            ST_SYNC: begin
                dout_d       = sync_word_s[SYNC_LEN-1];
                dout_valid_d = 1'b1;
            end
            ST_DATA: begin
                dout_d       = shift_d[DATA_W-1];
                dout_valid_d = 1'b1;
            end
            default: begin
                dout_d       = IDLE_BIT;
                dout_valid_d = 1'b0;
            end
        endcase
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_GAP);
        if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
            frame_count_d = frame_count_q + 8'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // State, datapath and output registers; async reset discards any partial frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            word_idx_q    <= '0;
            shift_q       <= '0;
            dout_q        <= IDLE_BIT;
            dout_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_idx_q    <= word_idx_d;
            shift_q       <= shift_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule
